cache_fill_fsm: RTL and testbench

- Cache-miss line-fill controller for the pipelined CPU's I-cache and D-cache. One instance per cache.
- On a miss, it fetches an 8-word line from the multi-cycle main memory and issues the data-array and tag-array write enables.
- It produces the fill word index and busy status consumed by the bitcell-based register and array storage directly downstream.

---
 rtl/cache_fill_fsm_if.sv | 51 +++++
 rtl/cache_fill_fsm.sv | 110 +++++++++++
 tb/tb_cache_fill_fsm.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_fsm_if.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm_if : miss request, memory and array-write bundle of the fill FSM
// Optional macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN (adds critical_valid)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface cache_fill_fsm_if #(
  parameter int ADDR_W     = 16,
  parameter int LINE_WORDS = 8
);
  localparam int IDX_W = $clog2(LINE_WORDS);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic              memory_read_en;
  logic [ADDR_W-1:0] memory_address;
  logic              fsm_busy;
  logic              write_data_array;
  logic [IDX_W-1:0]  word_index;
  logic              write_tag_array;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic              critical_valid;

  // master = fill controller, slave = cache pipeline / memory side
  modport master (
    input  miss_detected, miss_address, memory_data_valid,
    output memory_read_en, memory_address, fsm_busy,
    output write_data_array, word_index, write_tag_array, critical_valid
  );
  modport slave (
    output miss_detected, miss_address, memory_data_valid,
    input  memory_read_en, memory_address, fsm_busy,
    input  write_data_array, word_index, write_tag_array, critical_valid
  );
`else
  modport master (
    input  miss_detected, miss_address, memory_data_valid,
    output memory_read_en, memory_address, fsm_busy,
    output write_data_array, word_index, write_tag_array
  );
  modport slave (
    output miss_detected, miss_address, memory_data_valid,
    input  memory_read_en, memory_address, fsm_busy,
    input  write_data_array, word_index, write_tag_array
  );
`endif
endinterface

`default_nettype wire

// File: rtl/cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm : cache-miss line-fill controller (issue 8 reads, write array/tag)
// Optional macro: CACHE_FILL_CRITICAL_WORD_FIRST_EN (critical-word-first order)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cache_fill_fsm #(
  parameter int ADDR_W     = 16,
  parameter int LINE_WORDS = 8,
  parameter int MEM_LAT    = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  cache_fill_fsm_if.master bus
);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(2 * LINE_WORDS - 1);

  generate
    if (MEM_LAT < 1 || LINE_WORDS < 2 || (1 << IDX_W) != LINE_WORDS) begin : g_param_check
      $error("cache_fill_fsm: LINE_WORDS must be a power of two >= 2 and MEM_LAT >= 1");
    end
  endgenerate

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state;
  logic              busy;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic              issuing;
  logic              receiving;
  logic              last_recv;
  logic [IDX_W-1:0]  issue_pos;
  logic [IDX_W-1:0]  recv_pos;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0]  start;
  assign issue_pos = start + issue_cnt[IDX_W-1:0];
  assign recv_pos  = start + recv_cnt[IDX_W-1:0];
`else
  assign issue_pos = issue_cnt[IDX_W-1:0];
  assign recv_pos  = recv_cnt[IDX_W-1:0];
`endif

  assign issuing   = (state == FILL) && (issue_cnt < CNT_FULL);
  assign receiving = (state == FILL) && bus.memory_data_valid && (recv_cnt < CNT_FULL);
  assign last_recv = receiving && (recv_cnt == CNT_LAST);

  // Outputs are gated so everything reads zero whenever no fill activity is due.
  assign bus.fsm_busy         = busy;
  assign bus.memory_read_en   = issuing;
  assign bus.memory_address   = issuing ? (base + ADDR_W'({issue_pos, 1'b0})) : '0;
  assign bus.write_data_array = receiving;
  assign bus.word_index       = receiving ? recv_pos : '0;
  assign bus.write_tag_array  = last_recv;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  assign bus.critical_valid   = receiving && (recv_cnt == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      start     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss_detected) begin
            state     <= FILL;
            busy      <= 1'b1;
            base      <= bus.miss_address & BASE_MASK;
            issue_cnt <= '0;
            recv_cnt  <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            start     <= bus.miss_address[IDX_W:1];
`endif
          end
        end
        FILL: begin
          if (issuing) begin
            issue_cnt <= issue_cnt + 1'b1;
          end
          if (receiving) begin
            recv_cnt <= recv_cnt + 1'b1;
          end
          if (last_recv) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// tb_cache_fill_fsm : scoreboard bench for cache_fill_fsm with a latency memory model
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_cache_fill_fsm;
  localparam int MEM_LAT = 4;
  localparam int GAP_LEN = 3;

  typedef struct packed {
    logic [2:0] idx;
    logic       tag;
    logic       crit;
  } wr_exp_t;

  logic clk;
  logic rst;
  logic mem_valid;
  logic extra_valid;
  logic mon_en;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int cyc      = 0;
  int ret_total = 0;
  int gap_at   = -1;
  int gap_hold = 0;

  logic [15:0] addr_q[$];
  wr_exp_t     wr_q[$];
  int          busy_q[$];
  int          req_q[$];

  cache_fill_fsm_if #(.ADDR_W(16), .LINE_WORDS(8)) bus ();

  cache_fill_fsm #(.ADDR_W(16), .LINE_WORDS(8), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.memory_data_valid = mem_valid | extra_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int eff_start(input int s);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    return s;
`else
    return 0 * s;
`endif
  endfunction

  // Expected request/write sequence for one line with a hand-computed base and start word.
  function automatic void push_fill(input logic [15:0] base, input int start, input int busy_len);
    for (int k = 0; k < 8; k++) begin
      logic [2:0] w;
      wr_exp_t    e;
      w = 3'((eff_start(start) + k) % 8);
      addr_q.push_back(base + {12'd0, w, 1'b0});
      e.idx  = w;
      e.tag  = (k == 7);
      e.crit = (k == 0);
      wr_q.push_back(e);
    end
    busy_q.push_back(busy_len);
  endfunction

  // Memory model: each request returns MEM_LAT cycles later, in order, with an optional stall.
  initial begin
    mem_valid = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mem_valid = 1'b0;
      if (gap_hold > 0) begin
        gap_hold--;
      end else if (req_q.size() > 0 && req_q[0] + MEM_LAT <= cyc) begin
        void'(req_q.pop_front());
        mem_valid = 1'b1;
        ret_total++;
        if (ret_total == gap_at) gap_hold = GAP_LEN;
      end
      @(negedge clk);
      if (bus.memory_read_en === 1'b1) req_q.push_back(cyc);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a request or an array write.
  initial begin
    logic prev_busy;
    int   run;
    wr_exp_t e;
    prev_busy = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.memory_read_en === 1'b1) begin
          if (addr_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_request: address 0x%0h, none expected", bus.memory_address);
          end else begin
            chk("memory_address", bus.memory_address, addr_q.pop_front());
          end
        end
        if (bus.write_data_array === 1'b1) begin
          n_writes++;
          if (wr_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_write: word_index %0d, none expected", bus.word_index);
          end else begin
            e = wr_q.pop_front();
            chk("word_index", bus.word_index, e.idx);
            chk("write_tag_array", bus.write_tag_array, e.tag);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            chk("critical_valid", bus.critical_valid, e.crit);
`endif
          end
        end else begin
          chk("tag_without_write", bus.write_tag_array, 1'b0);
        end
        if (bus.fsm_busy === 1'b1) begin
          run++;
        end else if (prev_busy) begin
          if (busy_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_busy_run: length %0d, none expected", run);
          end else begin
            int exp_len;
            exp_len = busy_q.pop_front();
            if (exp_len >= 0) chk("busy_cycles", run, exp_len);
          end
          run = 0;
        end
        prev_busy = (bus.fsm_busy === 1'b1);
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.fsm_busy === 1'b0 && req_q.size() == 0 && !mem_valid && gap_hold == 0) break;
    end
    if (i == 300) begin
      n_checks++; n_errors++;
      $display("FAIL wait_idle_timeout: busy=%0b, pending=%0d", bus.fsm_busy, req_q.size());
    end
  endtask

  task automatic run_fill(input logic [15:0] addr, input logic [15:0] base,
                          input int start, input int busy_len);
    wait_idle();
    push_fill(base, start, busy_len);
    @(posedge clk); #1;
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    @(posedge clk); #1;
    bus.miss_detected = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, bus.fsm_busy, 1'b0);
    chk({tag, "_read_en"}, bus.memory_read_en, 1'b0);
    chk({tag, "_address"}, bus.memory_address, 16'h0000);
    chk({tag, "_write_data"}, bus.write_data_array, 1'b0);
    chk({tag, "_word_index"}, bus.word_index, 3'd0);
    chk({tag, "_write_tag"}, bus.write_tag_array, 1'b0);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
    chk({tag, "_critical"}, bus.critical_valid, 1'b0);
`endif
  endtask

  initial begin
    int base_writes;
    int idle;
    bit seen_fall;
    rst = 1'b0;
    mon_en = 1'b0;
    extra_valid = 1'b0;
    bus.miss_detected = 1'b0;
    bus.miss_address  = 16'h0000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    mon_en = 1'b1;

    // Basic fill
    run_fill(16'h1234, 16'h1230, 2, 12);

    // Stall gap of 3 cycles after the fourth returned word
    wait_idle();
    gap_at = ret_total + 4;
    run_fill(16'h2468, 16'h2460, 4, 15);

    // Miss during FILL must not relatch; valid while IDLE must not write
    run_fill(16'h0ABC, 16'h0AB0, 6, 12);
    repeat (2) @(posedge clk);
    #1;
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h8000;
    @(posedge clk); #1;
    bus.miss_detected = 1'b0;
    wait_idle();
    @(posedge clk); #1;
    extra_valid = 1'b1;
    @(negedge clk);
    chk("idle_valid_write", bus.write_data_array, 1'b0);
    chk("idle_valid_busy", bus.fsm_busy, 1'b0);
    @(posedge clk); #1;
    extra_valid = 1'b0;
    @(negedge clk);
    chk("idle_valid_busy_after", bus.fsm_busy, 1'b0);

    // Reset after five words: remaining writes abandoned, stale returns ignored
    base_writes = n_writes;
    run_fill(16'h1234, 16'h1230, 2, -1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (n_writes >= base_writes + 5) break;
    end
    chk("writes_before_reset", n_writes - base_writes, 5);
    rst = 1'b0;
    wr_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midfill_reset");
    run_fill(16'h0040, 16'h0040, 0, 12);

    // Back-to-back fills with address wrap; the second miss is held high
    wait_idle();
    push_fill(16'hFFF0, 5, 12);
    push_fill(16'h0000, 1, 12);
    @(posedge clk); #1;
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'hFFFA;
    @(posedge clk); #1;
    bus.miss_address  = 16'h0002;
    idle = 0;
    seen_fall = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.fsm_busy !== 1'b1) begin
        seen_fall = 1'b1;
        idle++;
      end else if (seen_fall) begin
        break;
      end
    end
    bus.miss_detected = 1'b0;
    chk("b2b_idle_cycles", idle, 1);

    // Critical-word-first vector (linear order when the option is off)
    run_fill(16'h123A, 16'h1230, 5, 12);

    wait_idle();
    repeat (3) @(negedge clk);
    chk("addr_queue_drained", addr_q.size(), 0);
    chk("write_queue_drained", wr_q.size(), 0);
    chk("busy_queue_drained", busy_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
